signed_sub_with_overflow_pipe: RTL and testbench



---
 rtl/signed_sub_with_overflow_pipe_pkg.sv | 20 ++
 rtl/signed_sub_with_overflow_pipe_if.sv | 25 ++
 rtl/signed_sub_with_overflow_pipe_stage.sv | 36 +++
 rtl/signed_sub_with_overflow_pipe.sv | 63 ++++++
 tb/tb_signed_sub_with_overflow_pipe.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/signed_sub_with_overflow_pipe_pkg.sv
// rtl/signed_sub_with_overflow_pipe_pkg.sv - shared constants and reference arithmetic for the signed subtractor pipe
package signed_sub_pkg;

  // Default operand width and the derived sign-bit index / clamp values
  localparam int SUB_WIDTH = 4;
  localparam int SUB_MSB   = SUB_WIDTH - 1;
  localparam logic [SUB_WIDTH-1:0] SAT_MAX = {1'b0, {SUB_MSB{1'b1}}};
  localparam logic [SUB_WIDTH-1:0] SAT_MIN = {1'b1, {SUB_MSB{1'b0}}};

  // Returns {overflow, diff} for a - b at the default width, wrap-around result
  function automatic logic [SUB_WIDTH:0] sub_with_ovf(input logic [SUB_WIDTH-1:0] a,
                                                      input logic [SUB_WIDTH-1:0] b);
    logic [SUB_WIDTH-1:0] d;
    logic                 o;
    d = a + ~b + SUB_WIDTH'(1);
    o = (a[SUB_MSB] != b[SUB_MSB]) && (d[SUB_MSB] != a[SUB_MSB]);
    return {o, d};
  endfunction

endpackage

// File: rtl/signed_sub_with_overflow_pipe_if.sv
// rtl/signed_sub_with_overflow_pipe_if.sv - operand/result handshake bundle for the signed subtractor pipe
interface signed_sub_with_overflow_pipe_if #(
  parameter int WIDTH = 4
);
  logic             up_valid;
  logic             up_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             down_valid;
  logic             down_ready;
  logic [WIDTH-1:0] diff;
  logic             overflow;

  // The pipe itself
  modport slave (
    input  up_valid, a, b, down_ready,
    output up_ready, down_valid, diff, overflow
  );

  // Operand producer plus result consumer
  modport master (
    output up_valid, a, b, down_ready,
    input  up_ready, down_valid, diff, overflow
  );
endinterface

// File: rtl/signed_sub_with_overflow_pipe_stage.sv
// rtl/signed_sub_with_overflow_pipe_stage.sv - generic valid/ready register slice
module signed_sub_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         v;
  logic [W-1:0] data_q;

  // Slot can take new data when empty or when its current content leaves this cycle
  assign in_ready  = !v || out_ready;
  assign out_valid = v;
  assign out_data  = data_q;

  // Load on accept; drop valid only when drained with nothing replacing it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v      <= 1'b0;
      data_q <= '0;
    end else if (in_valid && in_ready) begin
      v      <= 1'b1;
      data_q <= in_data;
    end else if (out_ready) begin
      v      <= 1'b0;
    end
  end

endmodule

// File: rtl/signed_sub_with_overflow_pipe.sv
// rtl/signed_sub_with_overflow_pipe.sv - two-stage signed a-b with overflow flag; SIGNED_SUB_SATURATE_EN clamps on overflow
module signed_sub_with_overflow_pipe
  import signed_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input logic                           clk,
  input logic                           rst,
  signed_sub_with_overflow_pipe_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  logic             s1_valid;
  logic             s2_ready;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_nb;
  logic [WIDTH-1:0] s2_diff_raw;
  logic [WIDTH-1:0] s2_diff_in;
  logic             s2_ovf_in;
  logic [WIDTH:0]   s2_payload;

  // Stage 1 captures the minuend and the inverted subtrahend
  signed_sub_pipe_stage #(.W(2 * WIDTH)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.up_valid),
    .in_ready  (bus.up_ready),
    .in_data   ({bus.a, ~bus.b}),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  ({s1_a, s1_nb})
  );

  // Finish the subtraction as a + ~b + 1; overflow when operand signs differ
  // (equivalently a and ~b share a sign) and the result sign departs from a
  always_comb begin
    s2_diff_raw = s1_a + s1_nb + WIDTH'(1);
    s2_ovf_in   = (s1_a[MSB] == s1_nb[MSB]) && (s2_diff_raw[MSB] != s1_a[MSB]);
    s2_diff_in  = s2_diff_raw;
`ifdef SIGNED_SUB_SATURATE_EN
    if (s2_ovf_in) begin
      s2_diff_in = s1_a[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
    end
`endif
  end

  // Stage 2 holds the finished result for the consumer
  signed_sub_pipe_stage #(.W(WIDTH + 1)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   ({s2_ovf_in, s2_diff_in}),
    .out_valid (bus.down_valid),
    .out_ready (bus.down_ready),
    .out_data  (s2_payload)
  );

  assign bus.overflow = s2_payload[WIDTH];
  assign bus.diff     = s2_payload[WIDTH-1:0];

endmodule

// File: tb/tb_signed_sub_with_overflow_pipe.sv
// tb/tb_signed_sub_with_overflow_pipe.sv - directed vector bench for the signed subtractor pipe
module tb_signed_sub_with_overflow_pipe;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  signed_sub_with_overflow_pipe_if #(.WIDTH(W)) bus ();

  signed_sub_with_overflow_pipe #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d_wrap;
    logic [W-1:0] d_sat;
    logic         ovf;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_diff(input vec_t v);
`ifdef SIGNED_SUB_SATURATE_EN
    return int'(v.d_sat);
`else
    return int'(v.d_wrap);
`endif
  endfunction

  vec_t tbl[10];
  vec_t strm[4];
  vec_t bp[3];

  initial begin
    //          a      b      wrap   sat    ovf
    tbl[0] = '{4'd3,  4'hB,  4'h8,  4'h7,  1'b1};  //  3 - -5
    tbl[1] = '{4'h8,  4'd1,  4'h7,  4'h8,  1'b1};  // -8 -  1
    tbl[2] = '{4'd0,  4'h8,  4'h8,  4'h7,  1'b1};  //  0 - -8
    tbl[3] = '{4'hF,  4'h8,  4'h7,  4'h7,  1'b0};  // -1 - -8
    tbl[4] = '{4'd7,  4'hF,  4'h8,  4'h7,  1'b1};  //  7 - -1
    tbl[5] = '{4'hF,  4'd7,  4'h8,  4'h8,  1'b0};  // -1 -  7
    tbl[6] = '{4'h8,  4'h8,  4'h0,  4'h0,  1'b0};  // -8 - -8
    tbl[7] = '{4'd7,  4'd7,  4'h0,  4'h0,  1'b0};  //  7 -  7
    tbl[8] = '{4'h9,  4'd2,  4'h7,  4'h8,  1'b1};  // -7 -  2
    tbl[9] = '{4'd6,  4'd2,  4'h4,  4'h4,  1'b0};  //  6 -  2

    strm[0] = '{4'd1,  4'd2,  4'hF,  4'hF,  1'b0};
    strm[1] = '{4'hD,  4'd4,  4'h9,  4'h9,  1'b0};
    strm[2] = '{4'd5,  4'hE,  4'h7,  4'h7,  1'b0};
    strm[3] = '{4'hC,  4'hC,  4'h0,  4'h0,  1'b0};

    bp[0]   = '{4'd2,  4'd3,  4'hF,  4'hF,  1'b0};
    bp[1]   = '{4'h8,  4'd1,  4'h7,  4'h8,  1'b1};
    bp[2]   = '{4'd6,  4'hF,  4'h7,  4'h7,  1'b0};

    rst = 1'b1;
    bus.up_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.down_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_down_valid", bus.down_valid, 0);
    chk("reset_diff", bus.diff, 0);
    chk("reset_overflow", bus.overflow, 0);
    rst = 1'b0;

    // Single transactions from the table, checking two-cycle latency
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.up_valid = 1'b1;
      bus.a = tbl[i].a;
      bus.b = tbl[i].b;
      bus.down_ready = 1'b1;
      #1;
      chk($sformatf("vec%0d_up_ready", i), bus.up_ready, 1);
      @(negedge clk);
      bus.up_valid = 1'b0;
      chk($sformatf("vec%0d_early_valid", i), bus.down_valid, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_down_valid", i), bus.down_valid, 1);
      chk($sformatf("vec%0d_diff", i), bus.diff, exp_diff(tbl[i]));
      chk($sformatf("vec%0d_overflow", i), bus.overflow, tbl[i].ovf);
    end

    // Back-to-back stream with consumer always ready
    begin
      int got = 0;
      int first_c = -1;
      int last_c = -1;
      @(negedge clk);
      for (int c = 0; c < 10; c++) begin
        if (c > 0) @(negedge clk);
        if (bus.down_valid) begin
          if (got < 4) begin
            chk($sformatf("stream%0d_diff", got), bus.diff, exp_diff(strm[got]));
            chk($sformatf("stream%0d_overflow", got), bus.overflow, strm[got].ovf);
          end
          if (first_c < 0) first_c = c;
          last_c = c;
          got++;
        end
        bus.up_valid = (c < 4);
        if (c < 4) begin
          bus.a = strm[c].a;
          bus.b = strm[c].b;
        end
      end
      chk("stream_count", got, 4);
      chk("stream_first_cycle", first_c, 2);
      chk("stream_consecutive", last_c - first_c, 3);
    end

    // Backpressure: consumer stalls four cycles while three pairs are offered
    begin
      int sent = 0;
      int got = 0;
      bus.up_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      for (int c = 0; c < 14; c++) begin
        if (c > 0) @(negedge clk);
        bus.down_ready = (c >= 4);
        bus.up_valid = (sent < 3);
        if (sent < 3) begin
          bus.a = bp[sent].a;
          bus.b = bp[sent].b;
        end
        #1;
        if (c == 2 || c == 3) begin
          chk($sformatf("bp_c%0d_accepted", c), sent, 2);
          chk($sformatf("bp_c%0d_up_ready", c), bus.up_ready, 0);
          chk($sformatf("bp_c%0d_down_valid", c), bus.down_valid, 1);
          chk($sformatf("bp_c%0d_diff_held", c), bus.diff, exp_diff(bp[0]));
        end
        if (bus.down_valid && bus.down_ready) begin
          if (got < 3) begin
            chk($sformatf("bp%0d_diff", got), bus.diff, exp_diff(bp[got]));
            chk($sformatf("bp%0d_overflow", got), bus.overflow, bp[got].ovf);
          end
          got++;
        end
        if (bus.up_valid && bus.up_ready) sent++;
      end
      chk("bp_sent", sent, 3);
      chk("bp_received", got, 3);
    end

    // Async reset with both stages full, then recovery
    @(negedge clk);
    bus.down_ready = 1'b0;
    bus.up_valid = 1'b1;
    bus.a = 4'd1;
    bus.b = 4'd1;
    @(negedge clk);
    bus.a = 4'd3;
    bus.b = 4'd1;
    @(negedge clk);
    #1;
    chk("rst_pre_full_up_ready", bus.up_ready, 0);
    chk("rst_pre_down_valid", bus.down_valid, 1);
    bus.a = 4'd4;
    bus.b = 4'd4;
    rst = 1'b1;
    #1;
    chk("rst_async_down_valid", bus.down_valid, 0);
    chk("rst_async_diff", bus.diff, 0);
    chk("rst_async_overflow", bus.overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.up_valid = 1'b1;
    bus.a = 4'd2;
    bus.b = 4'd1;
    bus.down_ready = 1'b1;
    @(negedge clk);
    bus.up_valid = 1'b0;
    chk("post_rst_early_valid", bus.down_valid, 0);
    @(negedge clk);
    chk("post_rst_down_valid", bus.down_valid, 1);
    chk("post_rst_diff", bus.diff, 1);
    chk("post_rst_overflow", bus.overflow, 0);
    @(negedge clk);
    chk("post_rst_no_dup", bus.down_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
